dac_frame_scheduler: RTL

//  Paces and feeds the two-channel serial DAC shifter. Generates the sample-rate tick, issues one
//  dac_sample_ready pulse per frame and selects which source owns the DAC for that frame.

---
 rtl/dac_frame_scheduler.sv | 114 +++++++++++
 1 files changed

// File: rtl/dac_frame_scheduler.sv
// rtl/dac_frame_scheduler.sv - frame pacing and source selection for the two-channel serial DAC shifter
//
// Generates one sample-rate tick per frame, loads the DAC sample registers from the
// owner selected at that tick, and pulses dac_sample_ready in the following cycle.
// Ownership changes only on a frame boundary. A PCM underrun repeats the last frame
// and bumps a saturating counter.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   cfg_period           requested clocks per frame (clamped up to MIN_PERIOD)
//   cfg_src              requested owner: 0=SID, 1=PCM, 2=TEST, 3=MUTE
//   cfg_test_val         constant driven on both channels when owner is TEST
//   sid_l, sid_r         SID mixer outputs, sampled only at the tick
//   pcm_l, pcm_r         PCM stream data
//   pcm_valid/pcm_ready  PCM handshake; a word is consumed when both are high
//   underflow_clr        clears underflow_cnt (wins over a same-cycle increment)
//   dac_sample_1/2       channel samples to the shifter
//   dac_sample_ready     one-cycle frame start pulse
//   cur_src              owner of the current frame
//   underflow_cnt        saturating count of PCM underruns
module dac_frame_scheduler #(
    parameter int                     SAMPLE_W   = 12,
    parameter int                     MIN_PERIOD = 34,
    parameter logic [SAMPLE_W-1:0]    MUTE_VAL   = 12'h800,
    parameter int                     UCNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         cfg_period,
    input  logic [1:0]          cfg_src,
    input  logic [SAMPLE_W-1:0] cfg_test_val,
    input  logic [SAMPLE_W-1:0] sid_l,
    input  logic [SAMPLE_W-1:0] sid_r,
    input  logic [SAMPLE_W-1:0] pcm_l,
    input  logic [SAMPLE_W-1:0] pcm_r,
    input  logic                pcm_valid,
    output logic                pcm_ready,
    input  logic                underflow_clr,
    output logic [SAMPLE_W-1:0] dac_sample_1,
    output logic [SAMPLE_W-1:0] dac_sample_2,
    output logic                dac_sample_ready,
    output logic [1:0]          cur_src,
    output logic [UCNT_W-1:0]   underflow_cnt
);

    typedef enum logic [1:0] {
        SRC_SID  = 2'd0,
        SRC_PCM  = 2'd1,
        SRC_TEST = 2'd2,
        SRC_MUTE = 2'd3
    } src_t;

    localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

    logic [15:0] cnt;
    logic [15:0] eff_period;
    logic        tick;
    logic        pcm_sel;

    assign tick       = (cnt == 16'd0);
    assign eff_period = (cfg_period < MIN_P) ? MIN_P : cfg_period;
    assign pcm_sel    = (cfg_src == SRC_PCM);

    // Gated by rst so a word presented during reset is never acknowledged.
    assign pcm_ready = tick && pcm_sel && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= MIN_P - 16'd1;
            dac_sample_1     <= MUTE_VAL;
            dac_sample_2     <= MUTE_VAL;
            dac_sample_ready <= 1'b0;
            cur_src          <= SRC_MUTE;
            underflow_cnt    <= '0;
        end else begin
            dac_sample_ready <= tick;

            if (tick) begin
                cnt     <= eff_period - 16'd1;
                cur_src <= cfg_src;
                case (cfg_src)
                    SRC_SID: begin
                        dac_sample_1 <= sid_l;
                        dac_sample_2 <= sid_r;
                    end
                    SRC_PCM: begin
                        // On underrun the registers simply keep the previous frame.
                        if (pcm_valid) begin
                            dac_sample_1 <= pcm_l;
                            dac_sample_2 <= pcm_r;
                        end
                    end
                    SRC_TEST: begin
                        dac_sample_1 <= cfg_test_val;
                        dac_sample_2 <= cfg_test_val;
                    end
                    default: begin
                        dac_sample_1 <= MUTE_VAL;
                        dac_sample_2 <= MUTE_VAL;
                    end
                endcase
            end else begin
                cnt <= cnt - 16'd1;
            end

            if (underflow_clr) begin
                underflow_cnt <= '0;
            end else if (tick && pcm_sel && !pcm_valid && (underflow_cnt != {UCNT_W{1'b1}})) begin
                underflow_cnt <= underflow_cnt + 1'b1;
            end
        end
    end

endmodule
